// File: rtl/sar_compare_search_pkg.sv
// Shared definitions for the successive-approximation search engine:
// FSM state encoding and the comparator-flag legality check.
package sar_compare_search_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESENT = 2'd1,
    DONE    = 2'd2
  } state_e;

  // A well-behaved comparator reports exactly one of: equal, greater, less.
  function automatic logic flags_legal(input logic eq, input logic geq, input logic lt);
    return (eq & geq & ~lt) | (~eq & geq & ~lt) | (~eq & ~geq & lt);
  endfunction

endpackage

// File: rtl/sar_compare_search_if.sv
// Control/comparator bundle of the search engine; the engine uses the slave view,
// the surrounding control FSM and comparator use the master view.
interface sar_compare_search_if #(
  parameter int WIDTH = 4,
  parameter int SW    = $clog2(WIDTH + 1)
);

  logic             start;
  logic [WIDTH-1:0] guess;
  logic             guess_valid;
  logic             cmp_valid;
  logic             AeqB;
  logic             AgeqB;
  logic             AltB;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic [SW-1:0]    steps;
  logic             err;

  modport slave (
    input  start, cmp_valid, AeqB, AgeqB, AltB,
    output guess, guess_valid, busy, done, result, steps, err
  );

  modport master (
    output start, cmp_valid, AeqB, AgeqB, AltB,
    input  guess, guess_valid, busy, done, result, steps, err
  );

endinterface

// File: rtl/sar_compare_search_sar_step.sv
// One successive-approximation step: folds the comparator verdict on the current
// trial into the partial result and forms the next trial value.
module sar_step
  import sar_compare_search_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int SW    = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] result_i,
  input  logic [WIDTH-1:0] guess_i,
  input  logic [SW-1:0]    idx_i,
  input  logic             eq_i,
  input  logic             geq_i,
  input  logic             lt_i,
  output logic [WIDTH-1:0] result_next_o,
  output logic [WIDTH-1:0] guess_next_o,
  output logic             last_step_o,
  output logic             illegal_o
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    result_next_o = result_i;
    guess_next_o  = guess_i;
    last_step_o   = 1'b0;
    illegal_o     = 1'b0;

    if (!flags_legal(eq_i, geq_i, lt_i)) begin
      illegal_o   = 1'b1;
      last_step_o = 1'b1;
    end else if (eq_i) begin
      result_next_o = guess_i;
      last_step_o   = 1'b1;
    end else begin
      if (geq_i) result_next_o = guess_i;
      if (idx_i == '0) begin
        last_step_o = 1'b1;
      end else begin
        guess_next_o = result_next_o | (ONE << (idx_i - SW'(1)));
      end
    end
  end

endmodule

// File: rtl/sar_compare_search.sv
// Successive-approximation search engine: drives trial values into a magnitude
// comparator and rebuilds the comparator's hidden A operand bit by bit.
module sar_compare_search
  import sar_compare_search_pkg::*;
#(
  parameter  int WIDTH = 4,
  localparam int SW    = $clog2(WIDTH + 1)
) (
  input logic                 clk,
  input logic                 rst_n,
  sar_compare_search_if.slave bus_if
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] guess_q, guess_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [SW-1:0]    steps_q, steps_d;
  logic [SW-1:0]    idx_q, idx_d;
  logic             err_q, err_d;
  logic             busy_q, busy_d;
  logic             guess_valid_q, guess_valid_d;
  logic             done_q, done_d;

  logic             handshake;
  logic [WIDTH-1:0] step_result;
  logic [WIDTH-1:0] step_guess;
  logic             step_last;
  logic             step_illegal;

  assign handshake = (state_q == PRESENT) && bus_if.cmp_valid;

  sar_step #(
    .WIDTH (WIDTH),
    .SW    (SW)
  ) u_step (
    .result_i      (result_q),
    .guess_i       (guess_q),
    .idx_i         (idx_q),
    .eq_i          (bus_if.AeqB),
    .geq_i         (bus_if.AgeqB),
    .lt_i          (bus_if.AltB),
    .result_next_o (step_result),
    .guess_next_o  (step_guess),
    .last_step_o   (step_last),
    .illegal_o     (step_illegal)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus_if.start) state_d = PRESENT;
      PRESENT: if (handshake && step_last) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Status flags are decoded from the next state so they leave the block registered.
  always_comb begin
    guess_d       = guess_q;
    result_d      = result_q;
    steps_d       = steps_q;
    idx_d         = idx_q;
    err_d         = err_q;
    busy_d        = (state_d == PRESENT);
    guess_valid_d = (state_d == PRESENT);
    done_d        = (state_d == DONE);

    unique case (state_q)
      IDLE: begin
        if (bus_if.start) begin
          result_d = '0;
          steps_d  = '0;
          err_d    = 1'b0;
          idx_d    = SW'(WIDTH - 1);
          guess_d  = {1'b1, {(WIDTH-1){1'b0}}};
        end
      end
      PRESENT: begin
        if (handshake) begin
          steps_d  = steps_q + SW'(1);
          result_d = step_result;
          err_d    = step_illegal;
          if (!step_last) begin
            idx_d   = idx_q - SW'(1);
            guess_d = step_guess;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      guess_q       <= '0;
      result_q      <= '0;
      steps_q       <= '0;
      idx_q         <= '0;
      err_q         <= 1'b0;
      busy_q        <= 1'b0;
      guess_valid_q <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      guess_q       <= guess_d;
      result_q      <= result_d;
      steps_q       <= steps_d;
      idx_q         <= idx_d;
      err_q         <= err_d;
      busy_q        <= busy_d;
      guess_valid_q <= guess_valid_d;
      done_q        <= done_d;
    end
  end

  assign bus_if.guess       = guess_q;
  assign bus_if.guess_valid = guess_valid_q;
  assign bus_if.busy        = busy_q;
  assign bus_if.done        = done_q;
  assign bus_if.result      = result_q;
  assign bus_if.steps       = steps_q;
  assign bus_if.err         = err_q;

endmodule

// File: doc/sar_compare_search.md
Name: sar_compare_search

Overview:
- Successive-approximation search engine: the "driver" side of the magnitude comparator.
- It proposes trial values on the comparator's B operand and consumes the AeqB/AgeqB/AltB flags. From those flags it reconstructs the unknown A operand bit by bit.
- Sits between a control FSM (start/done) and a comparator instance whose A input carries the hidden target.

Parameters:
- WIDTH, 4, operand width in bits (≥2; 2 matches the existing 2-bit comparator).
- SW, $clog2(WIDTH+1), width of the step counter (derived; do not override).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  begin a search; sampled only in IDLE.
- guess  output  WIDTH  trial value driven to comparator B input.
- guess_valid  output  1  guess is stable and awaiting comparison.
- cmp_valid  input  1  comparator flags valid for current guess (handshake completes when guess_valid & cmp_valid).
- AeqB  input  1  comparator flag A==B.
- AgeqB  input  1  comparator flag A>=B.
- AltB  input  1  comparator flag A<B.
- busy  output  1  search in progress.
- done  output  1  one-cycle pulse: result/steps/err valid.
- result  output  WIDTH  recovered A value (held until next start).
- steps  output  SW  number of compare handshakes used (held).
- err  output  1  inconsistent flags detected; valid with done, held until next start.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; guess=0, guess_valid=0, busy=0, done=0, result=0, steps=0, err=0. Reset mid-search aborts immediately with no done pulse.
- States: IDLE, PRESENT, DONE.
- IDLE: on start=1 → PRESENT, with:
  - result=0, steps=0, err=0;
  - bit index idx=WIDTH-1;
  - guess=1<<(WIDTH-1).
- PRESENT: busy=1, guess_valid=1. guess is held constant until the handshake; cmp_valid may stay low indefinitely.
- Handshake (cmp_valid=1 in PRESENT), in priority order:
  - steps increments by 1 on every handshake.
  - Illegal flag combo → DONE with err=1, result unchanged (partial). The only legal combos are {eq=1,geq=1,lt=0}, {eq=0,geq=1,lt=0} and {eq=0,geq=0,lt=1}.
  - AeqB=1 → result=guess, DONE (early exit).
  - AgeqB=1 → result=guess (keep trial bit); else result unchanged (drop bit).
  - If idx==0 → DONE. Else idx=idx-1 and guess=result_next | (1<<(idx-1)).
- DONE: lasts exactly one cycle; done=1, busy=0, guess_valid=0. Then → IDLE. start during DONE or PRESENT is ignored.
- Latency:
  - worst case = WIDTH handshakes;
  - with cmp_valid tied high, done is asserted WIDTH+1 cycles after the start cycle;
  - minimum is 1 handshake (target = 1<<(WIDTH-1)).
- guess outside PRESENT holds its last value. The comparator may see it, but guess_valid=0.
- All outputs are registered; no combinational path from inputs to outputs.

Decomposition:
- Shared package holds:
  - state encoding constants (IDLE=2'd0, PRESENT=2'd1, DONE=2'd2);
  - a function flags_legal(eq,geq,lt) returning 1 for the three legal combos.
- One natural sub-module: sar_step, purely combinational. It takes result, guess, idx and flags, and returns result_next, guess_next and last_step. The top keeps the FSM and registers.
- Bench reuses the existing 2-bit comparator for WIDTH=2 runs. A behavioural model covers wider runs.

Test Plan:
- WIDTH=4, target A=11, cmp_valid tied 1, pulse start → guesses 8,12,10,11; AeqB at 11 → done, result=11, steps=4, err=0.
- WIDTH=4, target A=8 → first guess 8 gives AeqB → done after 1 handshake, result=8, steps=1.
- WIDTH=4, targets 0 and 15:
  - 0 → guesses 8,4,2,1, all AltB → result=0, steps=4;
  - 15 → guesses 8,12,14,15 → result=15, steps=4.
- WIDTH=2 with the gate-level comparator, sweep A=0..3 → result==A every run; no err.
- Backpressure: hold cmp_valid=0 for 3 cycles after start → guess stays 8, guess_valid=1, busy=1; search then completes normally. start pulses while busy are ignored.
- Fault and reset:
  - drive AeqB=1, AltB=1 on first handshake → done with err=1, result=0, steps=1;
  - separate run: assert rst_n=0 mid-PRESENT → all outputs 0 immediately, no done pulse, next start works.
